multicycle_main_fsm: RTL

- Main controller for the multicycle ARM core. One shared ALU and one unified instruction/data memory are used over several cycles per instruction.
- Sequences fetch, decode, address generation, memory access, execute and writeback with a Moore state machine.
- Also decodes ALUControl, FlagW and NoWrite for data-processing instructions.
- PCS/RegW/MemW feed the existing conditional logic, which applies CondEx gating.

---
 rtl/multicycle_main_fsm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Main controller for the multicycle ARM core: Moore sequencer over fetch/decode/memory/execute
// phases, plus the data-processing ALU decoder. CondEx gating happens downstream.
module multicycle_main_fsm #(
  parameter logic [3:0] PC_IDX = 4'd15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic       nowrite_q, nowrite_d;

  logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op;
  logic       is_cmp;
  logic [1:0] flag_w;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StFetch;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nowrite_q <= nowrite_d;
    end
  end

  // Sequencer: next state plus the Moore datapath controls.
  always_comb begin
    state_d   = StFetch;
    ir_write  = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      StFetch: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        next_pc   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      StExecR: begin
        alu_op  = 1'b1;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_w = 1'b1;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // ALU decoder; only active while executing a data-processing instruction.
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    is_cmp     = 1'b0;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin
          ALUControl = 2'b00;
          flag_w     = {Funct[0], Funct[0]};
        end
        4'b0010: begin
          ALUControl = 2'b01;
          flag_w     = {Funct[0], Funct[0]};
        end
        4'b0000: begin
          ALUControl = 2'b10;
          flag_w     = {Funct[0], 1'b0};
        end
        4'b1100: begin
          ALUControl = 2'b11;
          flag_w     = {Funct[0], 1'b0};
        end
        4'b1010: begin
          ALUControl = 2'b01;
          flag_w     = 2'b11;
          is_cmp     = 1'b1;
        end
        default: begin
          ALUControl = 2'b00;
          flag_w     = 2'b00;
        end
      endcase
    end
  end

  // Latched at the end of execute so ALUWB still sees it; naturally zero again by FETCH.
  assign nowrite_d = is_cmp;
  assign NoWrite   = is_cmp | ((state_q == StAluWb) & nowrite_q);

  // Write enables are gated directly by Reset so nothing commits while it is held low.
  assign IRWrite = ir_write & Reset;
  assign NextPC  = next_pc & Reset;
  assign RegW    = reg_w & Reset;
  assign MemW    = mem_w & Reset;
  assign FlagW   = flag_w & {2{Reset}};
  assign PCS     = (branch | (reg_w & (Rd == PC_IDX))) & Reset;
  assign State   = state_q;

endmodule
